rf_wb_arbiter: RTL and testbench

- Write-port scheduler and scoreboard in front of the single-write-port register file of the pipelined MIPS-lite CPU.
- Shares the one write port between two writers:
  - the in-order WB stage, which has fixed priority;
  - a long-latency unit (mult/div), whose results are held in a small queue.
- Tracks registers with outstanding long-unit results and raises a combinational stall to the ID stage on RAW/WAW hazards against them.

---
 rtl/rf_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-port scheduler for the single-write-port register file: WB has fixed priority,
// long-unit results wait in a small FIFO, and a scoreboard stalls ID on pending registers.
module rf_wb_arbiter #(
   parameter int DEPTH = 2,
   parameter int DW    = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wb_we,
   input  logic [4:0]                wb_wn,
   input  logic [DW-1:0]             wb_wd,
   input  logic                      lu_issue,
   input  logic [4:0]                lu_issue_wn,
   input  logic                      lu_valid,
   input  logic [4:0]                lu_wn,
   input  logic [DW-1:0]             lu_wd,
   output logic                      lu_ready,
   input  logic [4:0]                id_rn1,
   input  logic [4:0]                id_rn2,
   input  logic [4:0]                id_wn,
   input  logic                      id_we,
   output logic                      stall,
   output logic                      RegWrite,
   output logic [4:0]                WN,
   output logic [DW-1:0]             WD,
   output logic [31:0]               busy_vec,
   output logic [$clog2(DEPTH):0]    q_count,
   output logic                      issue_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [4:0]    r_mem_wn [DEPTH];
   logic [DW-1:0] r_mem_wd [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_busy;
   logic          r_issue_err;

   logic          w_wb_valid;
   logic          w_q_valid;
   logic          w_push;
   logic          w_pop;
   logic          w_issue;
   logic [4:0]    w_head_wn;
   logic [DW-1:0] w_head_wd;
   logic [31:0]   w_busy_nxt;

   assign w_wb_valid = wb_we && (wb_wn != 5'd0);
   assign w_q_valid  = (r_count != '0);
   assign w_head_wn  = r_mem_wn[r_rd_ptr];
   assign w_head_wd  = r_mem_wd[r_rd_ptr];

   // The queue only drains when WB leaves the port idle; WB may starve it indefinitely.
   assign w_pop      = w_q_valid && !w_wb_valid;
   assign lu_ready   = (r_count != FULL_CNT);
   assign w_push     = lu_valid && lu_ready;
   assign w_issue    = lu_issue && (lu_issue_wn != 5'd0);

   // Head entries addressed to r0 still pop, but never assert the write enable.
   always_comb begin
      RegWrite = 1'b0;
      WN       = 5'd0;
      WD       = '0;
      if (rst_n) begin
         if (w_wb_valid) begin
            RegWrite = 1'b1;
            WN       = wb_wn;
            WD       = wb_wd;
         end else if (w_q_valid && (w_head_wn != 5'd0)) begin
            RegWrite = 1'b1;
            WN       = w_head_wn;
            WD       = w_head_wd;
         end
      end
   end

   // NOTE: the storage array has no reset; the pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_wn[r_wr_ptr] <= lu_wn;
         r_mem_wd[r_wr_ptr] <= lu_wd;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Set is applied after clear so a same-cycle issue to the draining register keeps it busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_pop)   w_busy_nxt[w_head_wn]   = 1'b0;
      if (w_issue) w_busy_nxt[lu_issue_wn] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy      <= '0;
         r_issue_err <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_issue && r_busy[lu_issue_wn]) r_issue_err <= 1'b1;
      end
   end

   assign stall = r_busy[id_rn1]
               || r_busy[id_rn2]
               || (id_we && r_busy[id_wn])
               || (lu_issue && r_busy[lu_issue_wn]);

   assign busy_vec  = r_busy;
   assign q_count   = r_count;
   assign issue_err = r_issue_err;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (DEPTH=2, DW=32): reset, issue/retire, WB priority,
// full-queue backpressure, r0 handling and scoreboard hazard edges.
module tb_rf_wb_arbiter;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wb_we;
   logic [4:0]    wb_wn;
   logic [DW-1:0] wb_wd;
   logic          lu_issue;
   logic [4:0]    lu_issue_wn;
   logic          lu_valid;
   logic [4:0]    lu_wn;
   logic [DW-1:0] lu_wd;
   logic          lu_ready;
   logic [4:0]    id_rn1;
   logic [4:0]    id_rn2;
   logic [4:0]    id_wn;
   logic          id_we;
   logic          stall;
   logic          RegWrite;
   logic [4:0]    WN;
   logic [DW-1:0] WD;
   logic [31:0]   busy_vec;
   logic [1:0]    q_count;
   logic          issue_err;

   int n_total  = 0;
   int n_passed = 0;

   rf_wb_arbiter #(.DEPTH(2), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_we(wb_we), .wb_wn(wb_wn), .wb_wd(wb_wd),
      .lu_issue(lu_issue), .lu_issue_wn(lu_issue_wn),
      .lu_valid(lu_valid), .lu_wn(lu_wn), .lu_wd(lu_wd), .lu_ready(lu_ready),
      .id_rn1(id_rn1), .id_rn2(id_rn2), .id_wn(id_wn), .id_we(id_we),
      .stall(stall), .RegWrite(RegWrite), .WN(WN), .WD(WD),
      .busy_vec(busy_vec), .q_count(q_count), .issue_err(issue_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_total++;
      assert (observed === expected) n_passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      wb_we = 1'b1; wb_wn = 5'd4; wb_wd = 32'h55;
      lu_issue = 1'b0; lu_issue_wn = 5'd0;
      lu_valid = 1'b0; lu_wn = 5'd0; lu_wd = '0;
      id_rn1 = 5'd0; id_rn2 = 5'd0; id_wn = 5'd0; id_we = 1'b0;
      settle();
      check("rst_regwrite", RegWrite, 1'b0);
      check("rst_wn", WN, 5'd0);
      check("rst_wd", WD, 32'h0);
      check("rst_qcount", q_count, 2'd0);
      check("rst_busy", busy_vec, 32'h0);
      check("rst_ready", lu_ready, 1'b1);
      check("rst_err", issue_err, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      settle();
      check("wb_pass_we", RegWrite, 1'b1);
      check("wb_pass_wn", WN, 5'd4);
      check("wb_pass_wd", WD, 32'h55);
      step();
      wb_we = 1'b0;

      // Issue r5, result arrives three cycles later.
      lu_issue = 1'b1; lu_issue_wn = 5'd5;
      settle();
      check("issue5_nostall", stall, 1'b0);
      step();
      lu_issue = 1'b0; id_rn1 = 5'd5;
      settle();
      check("busy5_set", busy_vec, 32'h20);
      check("stall_rn1", stall, 1'b1);
      step();
      step();
      lu_valid = 1'b1; lu_wn = 5'd5; lu_wd = 32'h1234;
      settle();
      check("no_bypass", RegWrite, 1'b0);
      step();
      lu_valid = 1'b0;
      settle();
      check("lu5_we", RegWrite, 1'b1);
      check("lu5_wn", WN, 5'd5);
      check("lu5_wd", WD, 32'h1234);
      check("lu5_q", q_count, 2'd1);
      check("lu5_busy_held", busy_vec, 32'h20);
      step();
      check("lu5_busy_clr", busy_vec, 32'h0);
      check("lu5_q_empty", q_count, 2'd0);
      check("lu5_stall_clr", stall, 1'b0);
      id_rn1 = 5'd0;

      // WB priority over a queued r7 result.
      lu_valid = 1'b1; lu_wn = 5'd7; lu_wd = 32'hAA;
      wb_we = 1'b1; wb_wn = 5'd3; wb_wd = 32'h33;
      step();
      lu_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("prio_wn", WN, 5'd3);
         check("prio_q", q_count, 2'd1);
         step();
      end
      wb_we = 1'b0;
      settle();
      check("drain7_wn", WN, 5'd7);
      check("drain7_wd", WD, 32'hAA);
      step();
      check("drain7_q", q_count, 2'd0);

      // Full queue with WB writing continuously and the long unit holding its result.
      wb_we = 1'b1; wb_wn = 5'd3;
      lu_valid = 1'b1; lu_wn = 5'd10; lu_wd = 32'hA1;
      settle();
      check("full_ready0", lu_ready, 1'b1);
      step();
      lu_wn = 5'd11; lu_wd = 32'hA2;
      settle();
      check("full_q1", q_count, 2'd1);
      check("full_ready1", lu_ready, 1'b1);
      step();
      lu_wn = 5'd12; lu_wd = 32'hA3;
      settle();
      check("full_q2", q_count, 2'd2);
      check("full_ready2", lu_ready, 1'b0);
      step();
      check("full_hold_q", q_count, 2'd2);
      wb_we = 1'b0;
      settle();
      check("full_drain_ready", lu_ready, 1'b0);
      check("fifo0_wn", WN, 5'd10);
      check("fifo0_wd", WD, 32'hA1);
      step();
      wb_we = 1'b1;
      check("after_drain_q", q_count, 2'd1);
      check("after_drain_ready", lu_ready, 1'b1);
      step();
      lu_valid = 1'b0;
      check("third_accept_q", q_count, 2'd2);
      wb_we = 1'b0;
      settle();
      check("fifo1_wn", WN, 5'd11);
      check("fifo1_wd", WD, 32'hA2);
      step();
      check("fifo2_wn", WN, 5'd12);
      check("fifo2_wd", WD, 32'hA3);
      step();
      check("fifo_empty", q_count, 2'd0);

      // r0 handling: WB to r0 leaves the port to the queue; issue to r0 marks nothing.
      lu_valid = 1'b1; lu_wn = 5'd13; lu_wd = 32'hB1;
      step();
      lu_valid = 1'b0;
      wb_we = 1'b1; wb_wn = 5'd0; wb_wd = 32'hFF;
      settle();
      check("r0_wb_we", RegWrite, 1'b1);
      check("r0_wb_wn", WN, 5'd13);
      check("r0_wb_wd", WD, 32'hB1);
      step();
      wb_we = 1'b0;
      check("r0_wb_q", q_count, 2'd0);
      lu_issue = 1'b1; lu_issue_wn = 5'd0;
      step();
      lu_issue = 1'b0;
      check("r0_issue_busy", busy_vec, 32'h0);
      check("r0_issue_err", issue_err, 1'b0);

      // Hazard edges around r9.
      lu_issue = 1'b1; lu_issue_wn = 5'd9;
      step();
      lu_issue = 1'b0;
      check("busy9", busy_vec, 32'h200);
      id_we = 1'b1; id_wn = 5'd9;
      settle();
      check("stall_waw", stall, 1'b1);
      id_we = 1'b0;
      settle();
      check("nostall_idwe0", stall, 1'b0);
      lu_valid = 1'b1; lu_wn = 5'd9; lu_wd = 32'hC9;
      step();
      lu_valid = 1'b0;
      lu_issue = 1'b1; lu_issue_wn = 5'd9;
      settle();
      check("stall_issue", stall, 1'b1);
      check("drain9_wn", WN, 5'd9);
      check("drain9_wd", WD, 32'hC9);
      step();
      lu_issue = 1'b0;
      check("setwins_busy", busy_vec, 32'h200);
      check("issue_err_set", issue_err, 1'b1);
      check("drain9_q", q_count, 2'd0);
      step();
      check("issue_err_sticky", issue_err, 1'b1);

      // Asynchronous reset in the middle of activity.
      lu_valid = 1'b1; lu_wn = 5'd20; lu_wd = 32'hD0;
      lu_issue = 1'b1; lu_issue_wn = 5'd20;
      step();
      lu_valid = 1'b0; lu_issue = 1'b0;
      check("pre_rst_q", q_count, 2'd1);
      #2;
      rst_n = 1'b0;
      settle();
      check("mid_rst_q", q_count, 2'd0);
      check("mid_rst_busy", busy_vec, 32'h0);
      check("mid_rst_err", issue_err, 1'b0);
      check("mid_rst_we", RegWrite, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post_rst_we", RegWrite, 1'b0);

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
